// File: rtl/ahb_sram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_sram_pkg : shared encodings and helpers for ahb_sram_ctrl_gen2 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // State names the kind of data phase currently on the bus
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_LATE = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_bank_model : single-port sync-read SRAM, byte writes, cs_n    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sram_bank_model
  import ahb_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_cs_n,
  input  logic [DATA_W/8-1:0] i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_q
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // q only changes on a read, so it holds across wait states
  always_ff @(posedge clk) begin
    if (!i_cs_n) begin
      if (|i_we) begin
        for (int b = 0; b < BYTES; b++) begin
          if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ahb_sram_ctrl_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_sram_ctrl_gen2 : AHB-Lite SRAM slave, banked, ERROR, wait st.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ahb_sram_ctrl_gen2
  import ahb_sram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_BYTES   = 32768,
  parameter int NUM_BANKS   = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hready_in,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int BYTES      = DATA_W / 8;
  localparam int LANE_W     = clog2(BYTES);
  localparam int MEM_AW     = clog2(MEM_BYTES);
  localparam int WORD_W     = MEM_AW - LANE_W;
  localparam int BANK_DEPTH = (MEM_BYTES / BYTES) / NUM_BANKS;
  localparam int IDX_W      = clog2(BANK_DEPTH);
  localparam int BANK_W     = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1;
  localparam int WC_W       = 2;

  // ---------------- address-phase decode ----------------
  logic              w_trans_ok;
  logic              w_accept;
  logic              w_err;
  logic [2:0]        w_align_mask;
  logic [BYTES-1:0]  w_be_span;
  logic [BYTES-1:0]  w_be;
  logic [WORD_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic [BANK_W-1:0] w_bank;
  logic              w_unused;

  always_comb begin
    w_trans_ok = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: w_trans_ok = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  w_trans_ok = 1'b0;
      default:                   w_trans_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_align_mask = 3'b111;
    w_be_span    = '1;
    case (hsize)
      3'd0: begin w_align_mask = 3'b000; w_be_span = BYTES'(1);  end
      3'd1: begin w_align_mask = 3'b001; w_be_span = BYTES'(3);  end
      3'd2: begin w_align_mask = 3'b011; w_be_span = BYTES'(15); end
      default: begin w_align_mask = 3'b111; w_be_span = '1; end
    endcase
  end

  assign w_accept = hsel & hready_in & w_trans_ok;
  assign w_err    = ({1'b0, haddr} >= (ADDR_W+1)'(MEM_BYTES))
                  | (hsize > 3'(LANE_W))
                  | (|(haddr[2:0] & w_align_mask));
  assign w_be     = w_be_span << haddr[LANE_W-1:0];
  assign w_word   = haddr[MEM_AW-1:LANE_W];
  assign w_idx    = w_word[IDX_W-1:0];
  assign w_unused = &{1'b0, hburst};

  if (NUM_BANKS > 1) begin : g_multi_bank
    assign w_bank = w_word[WORD_W-1:IDX_W];
  end else begin : g_single_bank
    assign w_bank = '0;
  end

  // ---------------- FSM and registered outputs ----------------
  state_t            r_state;
  logic [WC_W-1:0]   r_wait;
  logic              r_hready;
  logic [1:0]        r_hresp;
  logic [IDX_W-1:0]  r_idx;
  logic [BANK_W-1:0] r_bank;
  logic [BYTES-1:0]  r_be;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      r_state  <= ST_IDLE;
      r_wait   <= '0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
    end else if (r_hready) begin
      if (w_accept) begin
        if (w_err) begin
          r_state  <= ST_ERR1;
          r_hready <= 1'b0;
          r_hresp  <= HRESP_ERROR;
        end else if (hwrite) begin
          r_state  <= ST_WR;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
        end else if (r_state == ST_WR) begin
          r_state  <= ST_RD_LATE;
          r_hready <= 1'b0;
          r_hresp  <= HRESP_OKAY;
        end else begin
          r_state  <= ST_RD;
          r_wait   <= WC_W'(WAIT_STATES);
          r_hready <= (WAIT_STATES == 0);
          r_hresp  <= HRESP_OKAY;
        end
      end else begin
        r_state  <= ST_IDLE;
        r_hready <= 1'b1;
        r_hresp  <= HRESP_OKAY;
      end
    end else begin
      case (r_state)
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        ST_RD_LATE: begin
          r_state  <= ST_RD;
          r_wait   <= WC_W'(WAIT_STATES);
          r_hready <= (WAIT_STATES == 0);
        end
        ST_RD: begin
          r_wait   <= r_wait - 1'b1;
          r_hready <= (r_wait == WC_W'(1));
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (r_hready && w_accept) begin
      r_idx  <= w_idx;
      r_bank <= w_bank;
      r_be   <= w_be;
    end
  end

  // ---------------- SRAM port arbitration ----------------
  // A fresh read uses the live address unless the port is still busy with a write
  logic              w_acc_en;
  logic [BANK_W-1:0] w_acc_bank;
  logic [IDX_W-1:0]  w_acc_idx;
  logic [BYTES-1:0]  w_acc_we;
  logic [NUM_BANKS-1:0] w_cs_n;
  logic [DATA_W-1:0] w_q [NUM_BANKS];

  always_comb begin
    w_acc_en   = 1'b0;
    w_acc_bank = w_bank;
    w_acc_idx  = w_idx;
    w_acc_we   = '0;
    if (!hrst) begin
      if (r_state == ST_WR) begin
        w_acc_en   = 1'b1;
        w_acc_bank = r_bank;
        w_acc_idx  = r_idx;
        w_acc_we   = r_be;
      end else if (r_state == ST_RD_LATE) begin
        w_acc_en   = 1'b1;
        w_acc_bank = r_bank;
        w_acc_idx  = r_idx;
      end else if (r_hready && w_accept && !w_err && !hwrite) begin
        w_acc_en   = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_cs_n[b] = ~(w_acc_en & (w_acc_bank == BANK_W'(b)));

    sram_bank_model #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH)
    ) u_bank (
      .clk     (hclk),
      .i_cs_n  (w_cs_n[b]),
      .i_we    (w_acc_we),
      .i_addr  (w_acc_idx),
      .i_wdata (hwdata),
      .o_q     (w_q[b])
    );
  end

  always_comb begin
    hrdata = '0;
    if (r_state == ST_RD && r_hready) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (r_bank == BANK_W'(b)) hrdata = w_q[b];
      end
    end
  end

  assign hready_out = r_hready;
  assign hresp      = r_hresp;

endmodule
`default_nettype wire
